// File: rtl/pcw_dn_sequencer.sv
// Download bus sequencer: copies the boot ROM onto the dn_* bus after every core reset
// and forwards HPS ioctl writes, holding off the HPS with ioctl_wait while the boot copy owns the bus.
module pcw_dn_sequencer #(
  parameter int unsigned BOOT_LEN  = 276,
  parameter int unsigned ROM_LAT   = 1,
  parameter logic [7:0]  HPS_INDEX = 8'd1,
  parameter logic [15:0] EXEC_ADDR = 16'h0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        dn_go,
  output logic        dn_wr,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        execute_enable,
  output logic [15:0] execute_addr,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_B_RD   = 3'd1,
    S_B_WR   = 3'd2,
    S_B_GAP  = 3'd3,
    S_B_DONE = 3'd4,
    S_HPS    = 3'd5
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(BOOT_LEN - 1);
  // ROM_LAT=0 still spends one cycle in B_RD
  localparam logic [15:0] LAT_LAST = (ROM_LAT > 0) ? 16'(ROM_LAT - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] lat_q, lat_d;
  logic        pend_q, pend_d;
  logic        hold_vld_q, hold_vld_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        dn_go_q, dn_go_d;
  logic        dn_wr_q, dn_wr_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        exec_q, exec_d;

  logic hps_req;
  logic wr_req;
  logic boot_active;
  logic start_eff;
  logic serve;

  assign hps_req     = ioctl_download && (ioctl_index == HPS_INDEX);
  assign wr_req      = ioctl_wr && hps_req;
  assign boot_active = (state_q == S_B_RD) || (state_q == S_B_WR) ||
                       (state_q == S_B_GAP) || (state_q == S_B_DONE);
  assign start_eff   = start || pend_q;

  assign rom_addr       = idx_q;
  assign ioctl_wait     = boot_active && hps_req;
  assign dn_go          = dn_go_q;
  assign dn_wr          = dn_wr_q;
  assign dn_addr        = dn_addr_q;
  assign dn_data        = dn_data_q;
  assign execute_enable = exec_q;
  assign execute_addr   = EXEC_ADDR;
  assign busy           = (state_q != S_IDLE);

  // Next-state, hold-register and dn bus computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    pend_d      = pend_q;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    dn_wr_d     = 1'b0;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    serve       = 1'b0;

    // A write the bus cannot take now is parked once; further ones are dropped
    if (wr_req && !hold_vld_q && (boot_active || ((state_q == S_IDLE) && start_eff))) begin
      hold_vld_d  = 1'b1;
      hold_addr_d = ioctl_addr;
      hold_data_d = ioctl_data;
    end else begin
      hold_vld_d  = hold_vld_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_eff) begin
          state_d = S_B_RD;
          idx_d   = 16'd0;
          lat_d   = 16'd0;
          pend_d  = 1'b0;
        end else if (hps_req) begin
          state_d = S_HPS;
          serve   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_B_RD: begin
        if (start) begin
          idx_d = 16'd0;
          lat_d = 16'd0;
        end else if (lat_q >= LAT_LAST) begin
          state_d = S_B_WR;
        end else begin
          lat_d = lat_q + 16'd1;
        end
      end
      S_B_WR: begin
        if (start) begin
          state_d = S_B_RD;
          idx_d   = 16'd0;
          lat_d   = 16'd0;
        end else begin
          state_d   = S_B_GAP;
          dn_wr_d   = 1'b1;
          dn_addr_d = idx_q;
          dn_data_d = rom_data;
        end
      end
      S_B_GAP: begin
        if (start) begin
          state_d = S_B_RD;
          idx_d   = 16'd0;
          lat_d   = 16'd0;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_B_DONE;
        end else begin
          state_d = S_B_RD;
          idx_d   = idx_q + 16'd1;
          lat_d   = 16'd0;
        end
      end
      S_B_DONE: begin
        if (start) begin
          state_d = S_B_RD;
          idx_d   = 16'd0;
          lat_d   = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HPS: begin
        serve = 1'b1;
        if (start) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (!hps_req) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HPS;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Parked write goes out first; a new strobe in the same cycle takes its place
    if (serve) begin
      if (hold_vld_q) begin
        dn_wr_d   = 1'b1;
        dn_addr_d = hold_addr_q;
        dn_data_d = hold_data_q;
        if (wr_req) begin
          hold_addr_d = ioctl_addr;
          hold_data_d = ioctl_data;
        end else begin
          hold_vld_d  = 1'b0;
        end
      end else if (wr_req) begin
        dn_wr_d   = 1'b1;
        dn_addr_d = ioctl_addr;
        dn_data_d = ioctl_data;
      end else begin
        dn_wr_d   = 1'b0;
      end
    end else begin
      serve = 1'b0;
    end

    dn_go_d = (state_d == S_B_RD) || (state_d == S_B_WR) ||
              (state_d == S_B_GAP) || (state_d == S_HPS);
    exec_d  = (state_d == S_B_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 16'd0;
      lat_q       <= 16'd0;
      pend_q      <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_addr_q <= 16'd0;
      hold_data_q <= 8'd0;
      dn_go_q     <= 1'b0;
      dn_wr_q     <= 1'b0;
      dn_addr_q   <= 16'd0;
      dn_data_q   <= 8'd0;
      exec_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      pend_q      <= pend_d;
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      dn_go_q     <= dn_go_d;
      dn_wr_q     <= dn_wr_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
      exec_q      <= exec_d;
    end
  end

endmodule
